// File: rtl/trigger_match_unit_if.sv
// Config, sample and fire bundle for trigger_match_unit.
// Optional TRIG_HIT_LOG_EN adds hit_clr / hit_sticky.
interface trigger_match_unit_if #(
  parameter int XLEN         = 64,
  parameter int NUM_TRIGGERS = 4,
  parameter int NUM_SLOTS    = 4,
  parameter int CNT_W        = 16
);
  localparam int IDX_W = (NUM_TRIGGERS > 1) ? $clog2(NUM_TRIGGERS) : 1;

  logic                    cfg_we;
  logic [IDX_W-1:0]        cfg_idx;
  logic [XLEN-1:0]         cfg_tdata2;
  logic [3:0]              cfg_mode;
  logic [NUM_SLOTS-1:0]    cfg_slot_mask;
  logic                    cfg_chain;
  logic [CNT_W-1:0]        cfg_threshold;
  logic                    in_valid;
  logic [XLEN-1:0]         in_data [NUM_SLOTS];
  logic                    out_valid;
  logic [NUM_TRIGGERS-1:0] fire;
  logic                    any_fire;
`ifdef TRIG_HIT_LOG_EN
  logic [NUM_TRIGGERS-1:0] hit_clr;
  logic [NUM_TRIGGERS-1:0] hit_sticky;
`endif

  modport master (
    output cfg_we, cfg_idx, cfg_tdata2, cfg_mode, cfg_slot_mask, cfg_chain,
           cfg_threshold, in_valid, in_data,
    input  out_valid, fire, any_fire
`ifdef TRIG_HIT_LOG_EN
    , output hit_clr, input hit_sticky
`endif
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_tdata2, cfg_mode, cfg_slot_mask, cfg_chain,
           cfg_threshold, in_valid, in_data,
    output out_valid, fire, any_fire
`ifdef TRIG_HIT_LOG_EN
    , input hit_clr, output hit_sticky
`endif
  );
endinterface

// File: rtl/trigger_match_unit.sv
// Two-stage registered debug trigger matcher: slot compare, chain resolve, hit count.
// Optional sticky hit log is enabled by defining TRIG_HIT_LOG_EN.
module trigger_match_unit #(
  parameter int XLEN         = 64,
  parameter int NUM_TRIGGERS = 4,
  parameter int NUM_SLOTS    = 4,
  parameter int CNT_W        = 16
) (
  input logic                clk,
  input logic                rst,
  trigger_match_unit_if.slave bus
);
  localparam int IDX_W = (NUM_TRIGGERS > 1) ? $clog2(NUM_TRIGGERS) : 1;
  localparam int H     = XLEN / 2;

  logic [XLEN-1:0]         tdata2_q [NUM_TRIGGERS];
  logic [3:0]              mode_q   [NUM_TRIGGERS];
  logic [NUM_SLOTS-1:0]    mask_q   [NUM_TRIGGERS];
  logic [CNT_W-1:0]        th_q     [NUM_TRIGGERS];
  logic [CNT_W-1:0]        cnt_q    [NUM_TRIGGERS];
  logic [NUM_TRIGGERS-1:0] chain_q;

  logic                    s1_valid;
  logic [NUM_TRIGGERS-1:0] s1_raw;
  logic                    out_valid_q;
  logic [NUM_TRIGGERS-1:0] fire_q;
  logic                    any_q;

  logic [NUM_TRIGGERS-1:0] raw_c;
  logic [NUM_TRIGGERS-1:0] terminal;
  logic [NUM_TRIGGERS-1:0] ghit;
  logic [NUM_TRIGGERS-1:0] reach;
  logic [NUM_TRIGGERS-1:0] fire_c;

  // NAPOT: t ^ (t+1) covers the trailing ones plus the first zero; all-ones t masks everything
  function automatic logic match_fn(input logic [XLEN-1:0] v,
                                    input logic [XLEN-1:0] t,
                                    input logic [3:0]      m);
    logic [XLEN-1:0] napot_mask;
    logic eq, napot, lo, hi, r;
    napot_mask = ~(t ^ (t + XLEN'(1)));
    eq    = (v == t);
    napot = (((v ^ t) & napot_mask) == '0);
    lo    = ((v[H-1:0] & t[XLEN-1:H]) == t[H-1:0]);
    hi    = ((v[XLEN-1:H] & t[XLEN-1:H]) == t[H-1:0]);
    case (m)
      4'd0:    r = eq;
      4'd1:    r = napot;
      4'd2:    r = (v >= t);
      4'd3:    r = (v < t);
      4'd4:    r = lo;
      4'd5:    r = hi;
      4'd8:    r = ~eq;
      4'd9:    r = ~napot;
      4'd12:   r = ~lo;
      4'd13:   r = ~hi;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    raw_c = '0;
    for (int i = 0; i < NUM_TRIGGERS; i++)
      for (int j = 0; j < NUM_SLOTS; j++)
        if (mask_q[i][j] && match_fn(bus.in_data[j], tdata2_q[i], mode_q[i]))
          raw_c[i] = 1'b1;
  end

  // Group hit is the AND of raw across a chain run, reported only on its terminal trigger
  always_comb begin
    logic run;
    terminal = ~chain_q;
    terminal[NUM_TRIGGERS-1] = 1'b1;
    ghit = '0;
    run  = 1'b1;
    for (int i = 0; i < NUM_TRIGGERS; i++) begin
      run     = run & s1_raw[i];
      ghit[i] = terminal[i] & run;
      if (terminal[i]) run = 1'b1;
    end
  end

  always_comb begin
    logic [CNT_W-1:0] eff_th;
    reach  = '0;
    fire_c = '0;
    for (int i = 0; i < NUM_TRIGGERS; i++) begin
      eff_th    = (th_q[i] == '0) ? CNT_W'(1) : th_q[i];
      reach[i]  = (({1'b0, cnt_q[i]} + (CNT_W+1)'(1)) >= {1'b0, eff_th});
      fire_c[i] = s1_valid & ghit[i] & reach[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TRIGGERS; i++) begin
        tdata2_q[i] <= '0;
        mode_q[i]   <= '0;
        mask_q[i]   <= '0;
        th_q[i]     <= '0;
        cnt_q[i]    <= '0;
      end
      chain_q     <= '0;
      s1_valid    <= 1'b0;
      s1_raw      <= '0;
      out_valid_q <= 1'b0;
      fire_q      <= '0;
      any_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_TRIGGERS; i++) begin
        if (bus.cfg_we && (bus.cfg_idx == IDX_W'(i))) begin
          tdata2_q[i] <= bus.cfg_tdata2;
          mode_q[i]   <= bus.cfg_mode;
          mask_q[i]   <= bus.cfg_slot_mask;
          th_q[i]     <= bus.cfg_threshold;
          chain_q[i]  <= bus.cfg_chain;
          cnt_q[i]    <= '0;
        end else if (!terminal[i]) begin
          cnt_q[i] <= '0;
        end else if (s1_valid && ghit[i]) begin
          cnt_q[i] <= reach[i] ? '0 : cnt_q[i] + CNT_W'(1);
        end
      end
      s1_valid    <= bus.in_valid;
      s1_raw      <= bus.in_valid ? raw_c : '0;
      out_valid_q <= s1_valid;
      fire_q      <= fire_c;
      any_q       <= |fire_c;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.fire      = fire_q;
  assign bus.any_fire  = any_q;

`ifdef TRIG_HIT_LOG_EN
  logic [NUM_TRIGGERS-1:0] sticky_q;

  // Set from the registered fire wins over a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= '0;
    else     sticky_q <= (sticky_q & ~bus.hit_clr) | fire_q;
  end

  assign bus.hit_sticky = sticky_q;
`endif
endmodule
